// File: rtl/rand_byte_fifo.sv
// Packs debiased random bits MSB-first into WIDTH-bit words and buffers them in a
// show-ahead FIFO, with a sticky overflow flag and a repetition-count health alarm.
module rand_byte_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_random,
  input  logic                     i_valid,
  input  logic                     i_clear,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic                     o_rep_alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic [RW-1:0]    run;
  logic             last_bit;
  logic             overflow;
  logic             rep_alarm;

  logic [WIDTH-1:0] word;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic [RW-1:0]    run_nxt;

  always_comb begin
    word    = {sr[WIDTH-2:0], i_random};
    push    = i_valid && (bitcnt == CW'(WIDTH - 1));
    pop     = (level != '0) && i_ready;
    full    = (level == (AW + 1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    wr_en   = push && (!full || pop);
    run_nxt = run;
    if (run == '0 || i_random != last_bit)
      run_nxt = RW'(1);
    else if (run != RW'(REP_LIMIT))
      run_nxt = run + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      bitcnt    <= '0;
      sr        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      run       <= '0;
      last_bit  <= 1'b0;
      overflow  <= 1'b0;
      rep_alarm <= 1'b0;
    end else begin
      if (i_valid) begin
        sr       <= word;
        bitcnt   <= push ? '0 : bitcnt + 1'b1;
        run      <= run_nxt;
        last_bit <= i_random;
        if (run_nxt == RW'(REP_LIMIT))
          rep_alarm <= 1'b1;
      end
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        level <= level + 1'b1;
      else if (pop && !wr_en)
        level <= level - 1'b1;
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  // Word storage carries no reset; emptiness masks stale contents on o_data.
  always_ff @(posedge i_clk) begin
    if (wr_en && i_rst_n && !i_clear)
      mem[wr_ptr] <= word;
  end

  assign o_valid     = (level != '0);
  assign o_data      = o_valid ? mem[rd_ptr] : '0;
  assign o_level     = level;
  assign o_overflow  = overflow;
  assign o_rep_alarm = rep_alarm;

endmodule

// File: tb/tb_rand_byte_fifo.sv
// Bench for rand_byte_fifo: a word scoreboard checked every cycle, a table of packing
// vectors, and hand-written sequences for overflow, full push+pop, repetition and clear.
module tb_rand_byte_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, rnd, vld, clr, rdy;
  logic [7:0] data;
  logic       ov, ovf, alarm;
  logic [2:0] lvl;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_sr;
  int         m_cnt;
  logic       m_ovf;

  rand_byte_fifo #(.WIDTH(8), .DEPTH(DEPTH), .REP_LIMIT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_random(rnd), .i_valid(vld), .i_clear(clr),
    .o_data(data), .o_valid(ov), .i_ready(rdy), .o_level(lvl),
    .o_overflow(ovf), .o_rep_alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model for this cycle's inputs, clock, then compare every output.
  task automatic step();
    logic [7:0] w;
    if (!rst_n || clr) begin
      q.delete();
      m_sr  = '0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (ov === 1'b1 && rdy) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: DUT popped with no expected word");
        end else begin
          w = q.pop_front();
          chk("pop_data", {24'd0, data}, {24'd0, w});
        end
      end
      if (vld) begin
        w    = {m_sr[6:0], rnd};
        m_sr = w;
        if (m_cnt == 7) begin
          m_cnt = 0;
          if (q.size() < DEPTH) q.push_back(w);
          else m_ovf = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("level", {29'd0, lvl}, q.size());
    chk("valid", {31'd0, ov}, {31'd0, q.size() != 0});
    chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
    chk("head", {24'd0, data}, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
  endtask

  task automatic send_bit(input logic b);
    vld = 1'b1; rnd = b;
    step();
    vld = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      repeat (gap) step();
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] bits;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{bits: 8'b1011_0010, gap: 1, exp: 8'hB2};
    vecs[1] = '{bits: 8'b0000_0000, gap: 0, exp: 8'h00};
    vecs[2] = '{bits: 8'b1111_1111, gap: 2, exp: 8'hFF};
    vecs[3] = '{bits: 8'b0101_1010, gap: 3, exp: 8'h5A};

    rst_n = 1'b0; rnd = 1'b0; vld = 1'b0; clr = 1'b0; rdy = 1'b0;
    m_sr = '0; m_cnt = 0; m_ovf = 1'b0;

    // T1 reset with random bit activity
    repeat (2) begin
      vld = 1'($urandom_range(0, 1));
      rnd = 1'($urandom_range(0, 1));
      step();
    end
    vld = 1'b0;
    chk("rst_valid", {31'd0, ov}, 32'd0);
    chk("rst_level", {29'd0, lvl}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_alarm", {31'd0, alarm}, 32'd0);
    rst_n = 1'b1;
    step();

    // T2 packing vectors, consumer stalled
    for (int v = 0; v < 4; v++) begin
      do_clear();
      send_word(vecs[v].bits, vecs[v].gap);
      chk("pack_data", {24'd0, data}, {24'd0, vecs[v].exp});
      chk("pack_valid", {31'd0, ov}, 32'd1);
      chk("pack_level", {29'd0, lvl}, 32'd1);
    end

    // T3 overflow then drain
    do_clear();
    send_word(8'hA1, 0);
    send_word(8'hB2, 0);
    send_word(8'hC3, 0);
    send_word(8'hD4, 0);
    chk("t3_ovf_before", {31'd0, ovf}, 32'd0);
    send_word(8'hE5, 0);
    chk("t3_level", {29'd0, lvl}, 32'd4);
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    chk("t3_head", {24'd0, data}, 32'hA1);
    rdy = 1'b1;
    repeat (4) step();
    rdy = 1'b0;
    chk("t3_empty", {31'd0, ov}, 32'd0);
    chk("t3_ovf_sticky", {31'd0, ovf}, 32'd1);

    // T4 full FIFO, last bit of a new word coincides with a pop
    do_clear();
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    send_word(8'h33, 0);
    send_word(8'h44, 0);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h55 >> i));
    rdy = 1'b1;
    send_bit(1'b1);
    rdy = 1'b0;
    chk("t4_level", {29'd0, lvl}, 32'd4);
    chk("t4_ovf", {31'd0, ovf}, 32'd0);
    chk("t4_head", {24'd0, data}, 32'h22);
    rdy = 1'b1;
    repeat (4) step();
    rdy = 1'b0;
    chk("t4_drained", q.size(), 32'd0);

    // T5 repetition alarm
    do_clear();
    repeat (15) send_bit(1'b1);
    send_bit(1'b0);
    chk("t5_no_alarm", {31'd0, alarm}, 32'd0);
    do_clear();
    repeat (15) send_bit(1'b1);
    chk("t5_alarm_15", {31'd0, alarm}, 32'd0);
    send_bit(1'b1);
    chk("t5_alarm_16", {31'd0, alarm}, 32'd1);
    send_bit(1'b0);
    chk("t5_alarm_sticky", {31'd0, alarm}, 32'd1);

    // T6 clear in the middle of a word, with a bit offered on the clear cycle
    rdy = 1'b1;
    repeat (3) step();
    rdy = 1'b0;
    do_clear();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    vld = 1'b1; rnd = 1'b1; clr = 1'b1;
    step();
    vld = 1'b0; clr = 1'b0;
    chk("t6_alarm_cleared", {31'd0, alarm}, 32'd0);
    send_word(8'hF0, 1);
    chk("t6_data", {24'd0, data}, 32'hF0);
    chk("t6_level", {29'd0, lvl}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
